// File: rtl/sra32_module.sv
// 32-bit arithmetic right shifter for the ALU shift path.
// A five-row logarithmic mux network shifts the operand right by
// n = {select5..select1}. Each row is a 2:1 mux per bit. Vacated MSBs are
// filled with the operand's sign bit. One output register captures the
// fifth row.
module sra32_module (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] outfifth,
    input  logic [31:0] inp,
    input  logic        select1,
    input  logic        select2,
    input  logic        select3,
    input  logic        select4,
    input  logic        select5
);

    // Row enables, ordered by shift weight: bit gi enables a shift of 2**gi.
    logic [4:0] stage_sel;

    // shift_stage[0] is the operand, and shift_stage[gi+1] is the output of row gi.
    logic [5:0][31:0] shift_stage;

    // The sign bit is never altered by any row. Each row can therefore use its
    // own bit 31 as the fill value, and that bit still equals inp[31].
    assign stage_sel      = {select5, select4, select3, select2, select1};
    assign shift_stage[0] = inp;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_row
            localparam int SHIFT = 1 << gi;

            logic [31:0] shifted;

            // Candidate from this row: the previous row moved down by SHIFT bits,
            // with SHIFT copies of the sign placed on top.
            assign shifted = {{SHIFT{shift_stage[gi][31]}}, shift_stage[gi][31:SHIFT]};

            // 2:1 mux row: pass the previous row through, or take the shifted copy.
            always_comb begin
                shift_stage[gi+1] = stage_sel[gi] ? shifted : shift_stage[gi];
            end
        end
    endgenerate

    // Output register: cleared at once by reset, then loads the fifth row on every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outfifth <= 32'h0000_0000;
        end else begin
            outfifth <= shift_stage[5];
        end
    end

endmodule

// File: tb/tb_sra32_module.sv
// Directed and random checks for sra32_module.
// Inputs are driven on the falling edge, or just after a rising edge.
// Outputs are sampled 1 time unit after the rising edge.
module tb_sra32_module;

    logic        clk;
    logic        rst_n;
    logic [31:0] outfifth;
    logic [31:0] inp;
    logic [4:0]  sel;

    int vectors;
    int errors;

    sra32_module dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .outfifth (outfifth),
        .inp      (inp),
        .select1  (sel[0]),
        .select2  (sel[1]),
        .select3  (sel[2]),
        .select4  (sel[3]),
        .select5  (sel[4])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic shift used for the random traffic.
    function automatic logic [31:0] sra_ref(input logic [31:0] d, input logic [4:0] n);
        logic signed [31:0] sd;
        sd = $signed(d);
        return sd >>> n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("vec %0d %s inp=%h sel=%b out=%h exp=%h", vectors, tag, inp, sel, obs, exp);
    endtask

    // Drive one input set on the falling edge. Check the result just after the next rising edge.
    task automatic step(input string tag, input logic [31:0] d, input logic [4:0] s,
                        input logic [31:0] exp);
        @(negedge clk);
        inp = d;
        sel = s;
        @(posedge clk);
        #1;
        check(tag, outfifth, exp);
    endtask

    initial begin
        logic [31:0] exp_val;
        vectors = 0;
        errors  = 0;

        // Reset is held low with all inputs high. The output must be 0 before any clock edge.
        rst_n = 1'b0;
        inp   = 32'hFFFF_FFFF;
        sel   = 5'b11111;
        #1;
        check("reset_no_clk", outfifth, 32'h0000_0000);
        @(posedge clk); #1;
        check("reset_edge1", outfifth, 32'h0000_0000);
        @(posedge clk); #1;
        check("reset_edge2", outfifth, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Small shifts.
        step("n1_neg",  32'hFFFF_FFFE, 5'b00001, 32'hFFFF_FFFF);
        step("n2_neg",  32'hFFFF_FFFA, 5'b00010, 32'hFFFF_FFFE);
        step("n3_neg",  32'hFFFF_FFF2, 5'b00011, 32'hFFFF_FFFE);

        // Large shifts of the most negative value.
        step("n16_min", 32'h8000_0000, 5'b10000, 32'hFFFF_8000);
        step("n15_min", 32'h8000_0000, 5'b01111, 32'hFFFF_0000);
        step("n31_min", 32'h8000_0000, 5'b11111, 32'hFFFF_FFFF);

        // Positive operand.
        step("n31_pos", 32'h7FFF_FFFF, 5'b11111, 32'h0000_0000);
        step("n4_pos",  32'h7FFF_FFFF, 5'b00100, 32'h07FF_FFFF);
        step("n0_pos",  32'h7FFF_FFFF, 5'b00000, 32'h7FFF_FFFF);

        // Further hand-computed patterns.
        step("n0_neg",  32'h8000_0001, 5'b00000, 32'h8000_0001);
        step("n8_mix",  32'h1234_5678, 5'b01000, 32'h0012_3456);
        step("n8_negm", 32'hF234_5678, 5'b01000, 32'hFFF2_3456);
        step("n20_neg", 32'hA5A5_0000, 5'b10100, 32'hFFFF_FA5A);
        step("n31_one", 32'h0000_0001, 5'b11111, 32'h0000_0000);
        step("n1_pos",  32'h4000_0000, 5'b00001, 32'h2000_0000);

        // New inputs every cycle: each result appears one edge after its inputs.
        for (int i = 0; i < 1000; i++) begin
            inp = $urandom;
            sel = 5'($urandom_range(0, 31));
            exp_val = sra_ref(inp, sel);
            @(posedge clk);
            #1;
            check("random", outfifth, exp_val);
        end

        // Reset asserted between edges must clear the output immediately.
        step("pre_rst", 32'h8765_4321, 5'b00100, 32'hF876_5432);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_clear", outfifth, 32'h0000_0000);
        #1;
        rst_n = 1'b1;
        inp   = 32'hC000_0000;
        sel   = 5'b00010;
        #1;
        check("post_rel_hold", outfifth, 32'h0000_0000);
        @(posedge clk); #1;
        check("first_after_rel", outfifth, 32'hF000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
